// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 job scheduler.
package sha256_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_STATUS
  } sched_state_t;

  localparam int FIELD_W         = 16;
  localparam int DESC_MSG_LSB    = 16;
  localparam int DESC_OUT_LSB    = 0;

  localparam int STATUS_ERR_BIT  = 31;
  localparam int STATUS_JOBS_LSB = 0;

  localparam int DEFAULT_TIMEOUT      = 4096;
  localparam int DEFAULT_NUM_JOBS_MAX = 16;

  // Builds the status word: error flag on top, job count in the low byte.
  function automatic logic [31:0] make_status(input logic err, input logic [7:0] jobs);
    logic [31:0] w;
    w = '0;
    w[STATUS_ERR_BIT] = err;
    w[STATUS_JOBS_LSB +: 8] = jobs;
    return w;
  endfunction

endpackage

// File: rtl/sched_mem_mux.sv
// 2:1 memory-port multiplexer: the core owns the port while it runs.
module sched_mem_mux (
  input  logic        sel_core,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [31:0] core_write_data,
  input  logic        sched_we,
  input  logic [15:0] sched_addr,
  input  logic [31:0] sched_write_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data
);

  // Select the core request during RUN, otherwise the scheduler's own access.
  always_comb begin
    if (sel_core) begin
      mem_we         = core_we;
      mem_addr       = core_addr;
      mem_write_data = core_write_data;
    end else begin
      mem_we         = sched_we;
      mem_addr       = sched_addr;
      mem_write_data = sched_write_data;
    end
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Walks a descriptor list, launches the hash core per job, writes a status word.
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int NUM_JOBS_MAX = DEFAULT_NUM_JOBS_MAX,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] desc_addr,
  input  logic [7:0]  num_jobs,
  output logic        done,
  output logic        busy,
  output logic        error,
  output logic [7:0]  jobs_done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic [31:0] core_mem_read_data
);

  localparam logic [7:0]  MAX_JOBS    = 8'(NUM_JOBS_MAX);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  sched_state_t state, state_next;

  logic [15:0] desc_q;
  logic [7:0]  num_q;
  logic [15:0] idx;
  logic [15:0] idx_inc;
  logic [15:0] timer;
  logic        core_done_q;
  logic        core_done_rise;
  logic        bad_count;
  logic        timed_out;

  logic        sched_we;
  logic [15:0] sched_addr;
  logic [31:0] sched_write_data;

  assign mem_clk            = clk;
  assign core_mem_read_data = mem_read_data;
  assign core_start         = (state == S_LAUNCH);
  assign idx_inc            = idx + 16'd1;
  assign core_done_rise     = core_done & ~core_done_q;
  assign bad_count          = (num_jobs == 8'd0) || (num_jobs > MAX_JOBS);
  assign timed_out          = (timer >= TIMEOUT_CNT);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state decode and the scheduler's own memory access.
  always_comb begin
    state_next       = state;
    sched_we         = 1'b0;
    sched_addr       = 16'd0;
    sched_write_data = 32'd0;
    case (state)
      S_IDLE: begin
        if (start) state_next = bad_count ? S_STATUS : S_FETCH;
      end
      S_FETCH: begin
        sched_addr = desc_q + idx;
        state_next = S_WAIT;
      end
      S_WAIT:   state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_RUN;
      S_RUN: begin
        if (core_done_rise) state_next = S_NEXT;
        else if (timed_out) state_next = S_STATUS;
      end
      S_NEXT: begin
        state_next = (idx_inc == {8'd0, num_q}) ? S_STATUS : S_FETCH;
      end
      S_STATUS: begin
        sched_we         = 1'b1;
        sched_addr       = desc_q + {8'd0, num_q};
        sched_write_data = make_status(error, jobs_done);
        state_next       = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Batch bookkeeping, job address capture, timeout counter and result flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      desc_q            <= 16'd0;
      num_q             <= 8'd0;
      idx               <= 16'd0;
      timer             <= 16'd0;
      core_done_q       <= 1'b0;
      core_message_addr <= 16'd0;
      core_output_addr  <= 16'd0;
      jobs_done         <= 8'd0;
      done              <= 1'b0;
      busy              <= 1'b0;
      error             <= 1'b0;
    end else begin
      core_done_q <= core_done;
      case (state)
        S_IDLE: begin
          if (start) begin
            desc_q    <= desc_addr;
            num_q     <= num_jobs;
            idx       <= 16'd0;
            jobs_done <= 8'd0;
            done      <= 1'b0;
            busy      <= 1'b1;
            error     <= (num_jobs > MAX_JOBS);
          end
        end
        S_WAIT: begin
          core_message_addr <= mem_read_data[DESC_MSG_LSB +: FIELD_W];
          core_output_addr  <= mem_read_data[DESC_OUT_LSB +: FIELD_W];
        end
        S_LAUNCH: timer <= 16'd0;
        S_RUN: begin
          if (timer != 16'hFFFF) timer <= timer + 16'd1;
          if (!core_done_rise && timed_out) error <= 1'b1;
        end
        S_NEXT: begin
          jobs_done <= jobs_done + 8'd1;
          idx       <= idx_inc;
        end
        S_STATUS: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sched_mem_mux u_mux (
    .sel_core         (state == S_RUN),
    .core_we          (core_mem_we),
    .core_addr        (core_mem_addr),
    .core_write_data  (core_mem_write_data),
    .sched_we         (sched_we),
    .sched_addr       (sched_addr),
    .sched_write_data (sched_write_data),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data)
  );

endmodule
